// File: rtl/reg_rename_file_pkg.sv
// Shared types for the rename register file and its checkpoint controller.
package reg_rename_file_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ROB_ID_W = 4;
  localparam int DEF_NUM_CKPT = 4;

  localparam int REG_IDX_W  = $clog2(DEF_NUM_REGS);
  localparam int CKPT_ID_W  = $clog2(DEF_NUM_CKPT);

  typedef logic [REG_IDX_W-1:0]    reg_idx_t;
  typedef logic [DEF_ROB_ID_W-1:0] rob_id_t;
  typedef logic [DEF_DATA_W-1:0]   data_t;
  typedef logic [CKPT_ID_W-1:0]    ckpt_id_t;

  // Tag 0 marks a register whose value is already architectural.
  localparam rob_id_t INVALID_TAG = '0;
endpackage

// File: rtl/reg_ckpt_ctrl.sv
// Circular head/tail/count bookkeeping for the branch checkpoint buffer.
module reg_ckpt_ctrl
  import reg_rename_file_pkg::*;
#(
  parameter  int NUM_CKPT = DEF_NUM_CKPT,
  localparam int CIW      = $clog2(NUM_CKPT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic           i_alloc,
  input  logic           i_release,
  input  logic           i_restore,
  input  logic [CIW-1:0] i_restore_id,
  output logic [CIW-1:0] o_alloc_id,
  output logic           o_alloc_ok,
  output logic           o_full,
  output logic [CIW:0]   o_count,
  output logic           o_restore_live
);

  logic [CIW-1:0] r_head;
  logic [CIW-1:0] r_tail;
  logic [CIW:0]   r_count;
  logic           w_rel;
  logic [CIW-1:0] w_dist;
  logic [CIW-1:0] w_restore_tail;

  always_comb begin
    o_full         = (r_count == (CIW+1)'(NUM_CKPT));
    w_rel          = i_release && (r_count != '0);
    o_alloc_ok     = i_alloc && !i_restore && !i_flush && !o_full;
    // Distance from the oldest live slot; restore keeps everything up to and including it.
    w_dist         = i_restore_id - r_head;
    o_restore_live = ({1'b0, w_dist} < r_count);
    w_restore_tail = i_restore_id + CIW'(1);
    o_alloc_id     = r_tail;
    o_count        = r_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_restore) begin
      r_tail  <= w_restore_tail;
      r_head  <= r_head + CIW'(w_rel);
      r_count <= (CIW+1)'(w_dist) + (CIW+1)'(1) - (CIW+1)'(w_rel);
    end else begin
      r_tail  <= r_tail + CIW'(o_alloc_ok);
      r_head  <= r_head + CIW'(w_rel);
      r_count <= r_count + (CIW+1)'(o_alloc_ok) - (CIW+1)'(w_rel);
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with ROB-tag renaming and one-cycle checkpoint restore.
// Optional REG_COMMIT_BYPASS_EN forwards a same-cycle commit onto matching source reads.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int ROB_ID_W = DEF_ROB_ID_W,
  parameter  int NUM_CKPT = DEF_NUM_CKPT,
  localparam int RIW      = $clog2(NUM_REGS),
  localparam int CIW      = $clog2(NUM_CKPT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dispatch_valid,
  input  logic [RIW-1:0]      dispatch_rd,
  input  logic [ROB_ID_W-1:0] dispatch_rob_id,
  input  logic [RIW-1:0]      rs1,
  input  logic [RIW-1:0]      rs2,
  output logic [DATA_W-1:0]   v1,
  output logic [DATA_W-1:0]   v2,
  output logic [ROB_ID_W-1:0] q1,
  output logic [ROB_ID_W-1:0] q2,
  input  logic                commit_valid,
  input  logic [RIW-1:0]      commit_rd,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [DATA_W-1:0]   commit_data,
  input  logic                flush_all,
  input  logic                ckpt_alloc,
  output logic [CIW-1:0]      ckpt_alloc_id,
  output logic                ckpt_full,
  input  logic                ckpt_release,
  input  logic                ckpt_restore,
  input  logic [CIW-1:0]      ckpt_restore_id,
  output logic [CIW:0]        ckpt_count
);

  localparam logic [ROB_ID_W-1:0] NO_TAG = ROB_ID_W'(INVALID_TAG);

  logic [DATA_W-1:0]   r_v    [NUM_REGS];
  logic [ROB_ID_W-1:0] r_q    [NUM_REGS];
  logic [ROB_ID_W-1:0] r_snap [NUM_CKPT][NUM_REGS];
  logic [ROB_ID_W-1:0] w_q_next [NUM_REGS];
  logic                w_commit;
  logic                w_alloc_ok;
  logic                w_restore_live;

  reg_ckpt_ctrl #(.NUM_CKPT(NUM_CKPT)) u_ckpt_ctrl (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (flush_all),
    .i_alloc        (ckpt_alloc),
    .i_release      (ckpt_release),
    .i_restore      (ckpt_restore),
    .i_restore_id   (ckpt_restore_id),
    .o_alloc_id     (ckpt_alloc_id),
    .o_alloc_ok     (w_alloc_ok),
    .o_full         (ckpt_full),
    .o_count        (ckpt_count),
    .o_restore_live (w_restore_live)
  );

  assign w_commit = commit_valid && (commit_rd != '0);

  // Next tag table: flush beats restore beats rename; commit clears ride along.
  always_comb begin
    w_q_next = r_q;
    if (flush_all) begin
      for (int i = 0; i < NUM_REGS; i++) w_q_next[i] = NO_TAG;
    end else if (ckpt_restore) begin
      w_q_next = r_snap[ckpt_restore_id];
      if (w_commit && r_snap[ckpt_restore_id][commit_rd] == commit_rob_id)
        w_q_next[commit_rd] = NO_TAG;
    end else begin
      if (w_commit && r_q[commit_rd] == commit_rob_id &&
          !(dispatch_valid && dispatch_rd == commit_rd))
        w_q_next[commit_rd] = NO_TAG;
      if (dispatch_valid && dispatch_rd != '0)
        w_q_next[dispatch_rd] = dispatch_rob_id;
    end
    w_q_next[0] = NO_TAG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_v[i] <= '0;
        r_q[i] <= NO_TAG;
      end
    end else begin
      r_q <= w_q_next;
      if (w_commit) r_v[commit_rd] <= commit_data;
    end
  end

  // Snapshots need no reset: a slot only becomes visible once allocated.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CKPT; c++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_alloc_ok && CIW'(c) == ckpt_alloc_id)
          r_snap[c][r] <= w_q_next[r];
        else if (w_commit && RIW'(r) == commit_rd && r_snap[c][r] == commit_rob_id)
          r_snap[c][r] <= NO_TAG;
      end
    end
  end

  always_comb begin
    v1 = '0;
    q1 = NO_TAG;
    if (rs1 != '0) begin
      v1 = r_v[rs1];
      q1 = r_q[rs1];
`ifdef REG_COMMIT_BYPASS_EN
      if (commit_valid && commit_rd == rs1 && r_q[rs1] == commit_rob_id) begin
        v1 = commit_data;
        q1 = NO_TAG;
      end
`endif
    end
  end

  always_comb begin
    v2 = '0;
    q2 = NO_TAG;
    if (rs2 != '0) begin
      v2 = r_v[rs2];
      q2 = r_q[rs2];
`ifdef REG_COMMIT_BYPASS_EN
      if (commit_valid && commit_rd == rs2 && r_q[rs2] == commit_rob_id) begin
        v2 = commit_data;
        q2 = NO_TAG;
      end
`endif
    end
  end

  // Restoring a slot that is not live leaves the tag table undefined.
  assert property (@(posedge clk) disable iff (rst)
                   (ckpt_restore && !flush_all) |-> w_restore_live);

endmodule
